// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, datapath width.
package mips_pkg;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10
   } mdu_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Combinational result fixup: signs the magnitude product/quotient/remainder and
// applies the divide-by-zero result; shared by the FIX state and the fast multiply.
module md_sign_fix #(
   parameter int W = 32
) (
   input  logic             is_div_i,
   input  logic             neg_res_i,
   input  logic             neg_rem_i,
   input  logic             div_zero_i,
   input  logic [W-1:0]     raw_a_i,
   input  logic [2*W-1:0]   acc_i,
   output logic [W-1:0]     hi_o,
   output logic [W-1:0]     lo_o
);

   logic [2*W-1:0] prod;
   logic [W-1:0]   quo;
   logic [W-1:0]   rem;

   always_comb begin
      prod = neg_res_i ? (~acc_i + 1'b1) : acc_i;
      quo  = neg_res_i ? (~acc_i[W-1:0] + 1'b1) : acc_i[W-1:0];
      rem  = neg_rem_i ? (~acc_i[2*W-1:W] + 1'b1) : acc_i[2*W-1:W];
      if (!is_div_i) begin
         hi_o = prod[2*W-1:W];
         lo_o = prod[W-1:0];
      end else if (div_zero_i) begin
         // divide by zero hands back the raw dividend, not its magnitude
         hi_o = raw_a_i;
         lo_o = '1;
      end else begin
         hi_o = rem;
         lo_o = quo;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers (shift-add / restoring, 34-cycle latency).
// Define MDU_FAST_MUL_EN to complete multiplies combinationally in the launch cycle.
module mult_div_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             hilo_wr,
   input  logic             hilo_sel,
   input  logic [WIDTH-1:0] hilo_wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int W2 = 2 * WIDTH;

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] rawa_q, rawa_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             is_div_q, is_div_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic             dz_q, dz_d;
   logic             done_q, done_d;

   logic             signed_op, is_div, a_sgn, b_sgn, launch;
   logic [WIDTH-1:0] a_mag, b_mag, mul_add;
   logic [WIDTH:0]   mul_sum, div_trial;
   logic [W2-1:0]    mul_nxt, div_nxt;

   logic             sf_is_div, sf_neg_res, sf_neg_rem, sf_dz;
   logic [WIDTH-1:0] sf_raw_a, sf_hi, sf_lo;
   logic [W2-1:0]    sf_acc;

   assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
   assign is_div    = (op == MDU_DIV) || (op == MDU_DIVU);
   assign a_sgn     = signed_op && src_a[WIDTH-1];
   assign b_sgn     = signed_op && src_b[WIDTH-1];
   assign a_mag     = a_sgn ? (~src_a + 1'b1) : src_a;
   assign b_mag     = b_sgn ? (~src_b + 1'b1) : src_b;

   // multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
   assign mul_add   = acc_q[0] ? opb_q : '0;
   assign mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, mul_add};
   assign mul_nxt   = {mul_sum, acc_q[WIDTH-1:1]};

   // divide: acc = {remainder, dividend/quotient}, shifted left each step
   assign div_trial = acc_q[W2-1:WIDTH-1] - {1'b0, opb_q};
   assign div_nxt   = div_trial[WIDTH] ? {acc_q[W2-2:0], 1'b0}
                                       : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

`ifdef MDU_FAST_MUL_EN
   logic          fast_mul;
   logic [W2-1:0] fast_prod;

   assign fast_mul  = start && !is_div;
   assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
   assign launch    = start && is_div;

   always_comb begin
      if (fast_mul) begin
         sf_is_div  = 1'b0;
         sf_neg_res = a_sgn ^ b_sgn;
         sf_neg_rem = 1'b0;
         sf_dz      = 1'b0;
         sf_raw_a   = src_a;
         sf_acc     = fast_prod;
      end else begin
         sf_is_div  = is_div_q;
         sf_neg_res = neg_res_q;
         sf_neg_rem = neg_rem_q;
         sf_dz      = dz_q;
         sf_raw_a   = rawa_q;
         sf_acc     = acc_q;
      end
   end
`else
   assign launch = start;

   always_comb begin
      sf_is_div  = is_div_q;
      sf_neg_res = neg_res_q;
      sf_neg_rem = neg_rem_q;
      sf_dz      = dz_q;
      sf_raw_a   = rawa_q;
      sf_acc     = acc_q;
   end
`endif

   md_sign_fix #(.W(WIDTH)) u_sign_fix (
      .is_div_i   (sf_is_div),
      .neg_res_i  (sf_neg_res),
      .neg_rem_i  (sf_neg_rem),
      .div_zero_i (sf_dz),
      .raw_a_i    (sf_raw_a),
      .acc_i      (sf_acc),
      .hi_o       (sf_hi),
      .lo_o       (sf_lo)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      rawa_d    = rawa_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (launch) begin
               state_d   = RUN;
               cnt_d     = CNT_W'(WIDTH);
               acc_d     = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
               opb_d     = is_div ? b_mag : a_mag;
               rawa_d    = src_a;
               is_div_d  = is_div;
               neg_res_d = a_sgn ^ b_sgn;
               neg_rem_d = a_sgn;
               dz_d      = is_div && (src_b == '0);
            end
`ifdef MDU_FAST_MUL_EN
            else if (fast_mul) begin
               hi_d   = sf_hi;
               lo_d   = sf_lo;
               done_d = 1'b1;
            end
`endif
            else if (hilo_wr) begin
               if (hilo_sel) hi_d = hilo_wdata;
               else          lo_d = hilo_wdata;
            end
         end
         RUN: begin
            acc_d = is_div_q ? div_nxt : mul_nxt;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = FIX;
         end
         FIX: begin
            hi_d    = sf_hi;
            lo_d    = sf_lo;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opb_q     <= '0;
         rawa_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         rawa_q    <= rawa_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         done_q    <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
